// File: rtl/player_mover.sv
// Player paddle mover: rate-limited left/right steps, each candidate position is
// shown on the box outputs for an external collision check before it is committed.
module player_mover #(
    parameter int XSTART = 304,
    parameter int YTOP   = 440,
    parameter int PW     = 32,
    parameter int PH     = 16,
    parameter int STEP   = 4,
    parameter int XMIN   = 0,
    parameter int XMAX   = 639,
    parameter int DIV    = 833333
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        collide,
    output logic [10:0] topy,
    output logic [10:0] bottomy,
    output logic [10:0] leftx,
    output logic [10:0] rightx,
    output logic        probe,
    output logic        blocked,
    output logic        moved
);
    localparam int            CW       = $clog2(DIV);
    localparam logic [10:0]   X0       = 11'(XSTART);
    localparam logic [10:0]   XLO      = 11'(XMIN);
    localparam logic [10:0]   XHI      = 11'(XMAX - PW + 1);
    localparam logic [10:0]   STP      = 11'(STEP);
    localparam logic [10:0]   WM1      = 11'(PW - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, PROBE, CHECK, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [10:0]   cur_x;
    logic [10:0]   cand_x;
    logic [10:0]   next_x;
    logic [11:0]   right_sum;
    logic [11:0]   left_floor;

    assign tick    = (cnt == CNT_LAST);
    assign topy    = 11'(YTOP);
    assign bottomy = 11'(YTOP + PH - 1);

    // Free-running move-rate divider, independent of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CW'(1);
    end

    // 12-bit arithmetic keeps both clamps free of wrap-around.
    always_comb begin
        right_sum  = {1'b0, cur_x} + {1'b0, STP};
        left_floor = {1'b0, XLO} + {1'b0, STP};
        if (btn_left)
            next_x = ({1'b0, cur_x} < left_floor) ? XLO : (cur_x - STP);
        else
            next_x = (right_sum > {1'b0, XHI}) ? XHI : right_sum[10:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_x   <= X0;
            cand_x  <= X0;
            leftx   <= X0;
            rightx  <= X0 + WM1;
            probe   <= 1'b0;
            blocked <= 1'b0;
            moved   <= 1'b0;
        end else begin
            blocked <= 1'b0;
            moved   <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && (btn_left ^ btn_right) && (next_x != cur_x)) begin
                        cand_x <= next_x;
                        leftx  <= next_x;
                        rightx <= next_x + WM1;
                        probe  <= 1'b1;
                        state  <= PROBE;
                    end
                end
                PROBE: state <= CHECK;
                CHECK: begin
                    probe <= 1'b0;
                    state <= DONE;
                    if (collide) begin
                        blocked <= 1'b1;
                        leftx   <= cur_x;
                        rightx  <= cur_x + WM1;
                    end else begin
                        // box outputs already hold the candidate
                        moved <= 1'b1;
                        cur_x <= cand_x;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover at DIV=4; extra instances start near each edge.
module tb_player_mover;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_left = 1'b0;
    logic btn_right = 1'b0;
    logic collide = 1'b0;

    logic [10:0] topy[3];
    logic [10:0] bottomy[3];
    logic [10:0] leftx[3];
    logic [10:0] rightx[3];
    logic        probe[3];
    logic        blocked[3];
    logic        moved[3];

    int n_cmp = 0;
    int n_bad = 0;

    player_mover #(.DIV(DIV)) u_dut (
        .clk(clk), .rst_n(rst_n), .btn_left(btn_left), .btn_right(btn_right), .collide(collide),
        .topy(topy[0]), .bottomy(bottomy[0]), .leftx(leftx[0]), .rightx(rightx[0]),
        .probe(probe[0]), .blocked(blocked[0]), .moved(moved[0])
    );

    player_mover #(.DIV(DIV), .XSTART(2)) u_lo (
        .clk(clk), .rst_n(rst_n), .btn_left(btn_left), .btn_right(btn_right), .collide(collide),
        .topy(topy[1]), .bottomy(bottomy[1]), .leftx(leftx[1]), .rightx(rightx[1]),
        .probe(probe[1]), .blocked(blocked[1]), .moved(moved[1])
    );

    player_mover #(.DIV(DIV), .XSTART(606)) u_hi (
        .clk(clk), .rst_n(rst_n), .btn_left(btn_left), .btn_right(btn_right), .collide(collide),
        .topy(topy[2]), .bottomy(bottomy[2]), .leftx(leftx[2]), .rightx(rightx[2]),
        .probe(probe[2]), .blocked(blocked[2]), .moved(moved[2])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Release lands on a negedge, so the first tick edge is DIV posedges later.
    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_probe(input int s, input int bound, output int n);
        n = 0;
        while (!probe[s] && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Runs n cycles and counts how often probe or moved of instance s is seen high.
    task automatic idle_watch(input int s, input int n, output int np, output int nm);
        np = 0;
        nm = 0;
        repeat (n) begin
            @(negedge clk);
            if (probe[s]) np++;
            if (moved[s] || blocked[s]) nm++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n, np, nm;

        // Reset state and idle with no buttons
        cyc(2);
        chk("rst_leftx", leftx[0], 304);
        chk("rst_rightx", rightx[0], 335);
        chk("rst_topy", topy[0], 440);
        chk("rst_bottomy", bottomy[0], 455);
        chk("rst_probe", probe[0], 0);
        chk("rst_moved", moved[0], 0);
        chk("rst_blocked", blocked[0], 0);
        rst_n = 1'b1;
        idle_watch(0, 20, np, nm);
        chk("idle_probe_cnt", np, 0);
        chk("idle_pulse_cnt", nm, 0);
        chk("idle_leftx", leftx[0], 304);
        chk("idle_rightx", rightx[0], 335);

        // Right move, no collision, two ticks in a row
        btn_right = 1'b1;
        do_reset();
        wait_probe(0, 8, n);
        chk("first_tick_lat", n, 4);
        chk("r1_probe", probe[0], 1);
        chk("r1_leftx", leftx[0], 308);
        chk("r1_rightx", rightx[0], 339);
        chk("r1_topy", topy[0], 440);
        cyc(1);
        chk("r1_check_probe", probe[0], 1);
        chk("r1_check_moved", moved[0], 0);
        cyc(1);
        chk("r1_done_probe", probe[0], 0);
        chk("r1_done_moved", moved[0], 1);
        chk("r1_done_blocked", blocked[0], 0);
        chk("r1_done_leftx", leftx[0], 308);
        cyc(1);
        chk("r1_idle_moved", moved[0], 0);
        wait_probe(0, 8, n);
        chk("r2_tick_gap", n, 1);
        chk("r2_leftx", leftx[0], 312);
        btn_right = 1'b0;
        cyc(2);
        chk("r2_done_moved", moved[0], 1);
        chk("r2_done_leftx", leftx[0], 312);
        chk("r2_done_rightx", rightx[0], 343);

        // Right move rejected by collide
        btn_right = 1'b1;
        collide = 1'b1;
        do_reset();
        wait_probe(0, 8, n);
        chk("blk_probe_leftx", leftx[0], 308);
        cyc(2);
        chk("blk_blocked", blocked[0], 1);
        chk("blk_moved", moved[0], 0);
        chk("blk_probe", probe[0], 0);
        chk("blk_leftx", leftx[0], 304);
        chk("blk_rightx", rightx[0], 335);
        cyc(1);
        chk("blk_pulse_end", blocked[0], 0);
        collide = 1'b0;

        // Both buttons: never moves
        btn_left = 1'b1;
        btn_right = 1'b1;
        do_reset();
        idle_watch(0, 12, np, nm);
        chk("both_probe_cnt", np, 0);
        chk("both_leftx", leftx[0], 304);

        // Reset during CHECK aborts the move
        btn_left = 1'b0;
        do_reset();
        wait_probe(0, 8, n);
        cyc(1);
        chk("abort_in_check", probe[0], 1);
        rst_n = 1'b0;
        #1;
        chk("abort_leftx", leftx[0], 304);
        chk("abort_probe", probe[0], 0);
        chk("abort_moved", moved[0], 0);
        chk("abort_blocked", blocked[0], 0);
        btn_right = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        idle_watch(0, 8, np, nm);
        chk("abort_pulse_cnt", nm, 0);
        chk("abort_leftx_after", leftx[0], 304);

        // Left edge: 2 -> 0, then no further probe
        btn_left = 1'b1;
        do_reset();
        wait_probe(1, 8, n);
        chk("lo_probe", probe[1], 1);
        chk("lo_cand_leftx", leftx[1], 0);
        chk("lo_cand_rightx", rightx[1], 31);
        cyc(2);
        chk("lo_moved", moved[1], 1);
        chk("lo_leftx", leftx[1], 0);
        idle_watch(1, 8, np, nm);
        chk("lo_no_probe", np, 0);
        chk("lo_leftx_hold", leftx[1], 0);

        // Right edge: 606 -> 608 clamped, then no further probe
        btn_left = 1'b0;
        btn_right = 1'b1;
        do_reset();
        wait_probe(2, 8, n);
        chk("hi_probe", probe[2], 1);
        chk("hi_cand_leftx", leftx[2], 608);
        chk("hi_cand_rightx", rightx[2], 639);
        cyc(2);
        chk("hi_moved", moved[2], 1);
        chk("hi_leftx", leftx[2], 608);
        idle_watch(2, 8, np, nm);
        chk("hi_no_probe", np, 0);
        chk("hi_rightx_hold", rightx[2], 639);
        btn_right = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
